uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_pkg.sv | 44 ++++
 rtl/uart_gap_timer.sv | 43 ++++
 rtl/uart_frame_parser.sv | 153 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
// Shared constants, FSM state type and small index helpers for the UART frame
// parser. A frame is 19 bytes:
//   [0]=0x0A, [1..4]=Num_x, [5]=0x0A, [6..9]=Num_s, [10]=0x0A,
//   [11..14]=cnt_high, [15..18]=cnt_low  (all multi-byte fields LSB first).
// No ports (package).
// ---------------------------------------------------------------------------
package uart_frame_pkg;

    localparam logic [7:0] DELIM     = 8'h0A;
    localparam int         FRAME_LEN = 19;
    localparam int         IDX_W     = $clog2(FRAME_LEN);

    // First byte position of each multi-byte field.
    localparam int NUMX_START = 1;
    localparam int NUMS_START = 6;
    localparam int CNTH_START = 11;
    localparam int CNTL_START = 15;

    // Positions that must carry the delimiter inside a frame.
    localparam logic [IDX_W-1:0] DELIM_IDX_A = IDX_W'(5);
    localparam logic [IDX_W-1:0] DELIM_IDX_B = IDX_W'(10);

    // Top byte of the two 28-bit fields; only its low nibble is meaningful.
    localparam logic [IDX_W-1:0] NIB_IDX_A = IDX_W'(NUMX_START + 3);
    localparam logic [IDX_W-1:0] NIB_IDX_B = IDX_W'(NUMS_START + 3);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        HUNT,
        RECV
    } frame_state_t;

    function automatic logic is_delim_idx(input logic [IDX_W-1:0] i);
        return (i == DELIM_IDX_A) || (i == DELIM_IDX_B);
    endfunction

    function automatic logic is_nibble_idx(input logic [IDX_W-1:0] i);
        return (i == NIB_IDX_A) || (i == NIB_IDX_B);
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// ---------------------------------------------------------------------------
// uart_gap_timer
// Counts idle clocks between received bytes while a frame is in progress.
// 'expired' is asserted during the idle clock whose completion brings the
// count to TIMEOUT_CYC, so the parser registers the abort on that same edge.
// A byte in that cycle (clr=1) suppresses expiry and restarts the count.
// Ports:
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   run     in  1  count enable (parser is inside a frame)
//   clr     in  1  restart count (a byte was received)
//   expired out 1  idle limit reached this cycle with no byte
// ---------------------------------------------------------------------------
module uart_gap_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    // The counter holds the number of completed idle clocks since the last
    // byte. It is held at zero outside a frame and saturates at the limit so
    // it can never wrap back into a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || clr) begin
            count <= '0;
        end else if (count != CW'(TIMEOUT_CYC)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = run && !clr && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
// Reassembles 19-byte frames from a byte strobe stream, validates them and
// publishes the four payload fields only when a complete frame arrives.
// Partial data is kept in an internal shadow register that never reaches the
// outputs; an aborted frame leaves the outputs untouched.
//
// Optional feature macro: FRAME_CHECK_EN
//   defined   - bytes 5/10 must be 0x0A and bytes 4/9 must have a zero upper
//               nibble, otherwise the frame aborts with frame_err.
//   undefined - those bytes are not checked, upper nibbles at 4/9 are
//               dropped, and frame_err only reports inter-byte timeouts.
//
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   rdsig        in   1  received-byte strobe
//   rxdata       in   8  received byte (valid with rdsig)
//   Num_x        out 28  last committed Num_x field
//   Num_s        out 28  last committed Num_s field
//   cnt_high     out 32  last committed cnt_high field
//   cnt_low      out 32  last committed cnt_low field
//   frame_valid  out  1  one-cycle pulse on frame commit
//   frame_err    out  1  one-cycle pulse on frame abort
// ---------------------------------------------------------------------------
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdsig,
    input  logic [7:0]  rxdata,
    output logic [27:0] Num_x,
    output logic [27:0] Num_s,
    output logic [31:0] cnt_high,
    output logic [31:0] cnt_low,
    output logic        frame_valid,
    output logic        frame_err
);

    frame_state_t                  state;
    logic [IDX_W-1:0]              idx;
    logic [FRAME_LEN-1:0][7:0]     shadow;
    logic                          gap_expired;
    logic                          byte_bad;
    logic [7:0]                    store_byte;
    logic [31:0]                   numx_word;
    logic [31:0]                   nums_word;
    logic [31:0]                   cnth_word;
    logic                          unused_bits;

    uart_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state == RECV),
        .clr     (rdsig),
        .expired (gap_expired)
    );

    // Decide whether the byte at the current index is acceptable and what
    // value goes into the shadow. Without checking, the top nibble of the
    // 28-bit fields is simply discarded on the way in.
    always_comb begin
        byte_bad   = 1'b0;
        store_byte = rxdata;
`ifdef FRAME_CHECK_EN
        if (is_delim_idx(idx) && (rxdata != DELIM)) begin
            byte_bad = 1'b1;
        end
        if (is_nibble_idx(idx) && (rxdata[7:4] != 4'h0)) begin
            byte_bad = 1'b1;
        end
`else
        if (is_nibble_idx(idx)) begin
            store_byte = {4'h0, rxdata[3:0]};
        end
`endif
    end

    // Packed shadow slices give the LSB-first fields directly: the byte at
    // the higher index lands in the more significant position.
    assign numx_word = shadow[NUMX_START +: 4];
    assign nums_word = shadow[NUMS_START +: 4];
    assign cnth_word = shadow[CNTH_START +: 4];

    // Delimiter slots and the top nibbles of the 28-bit fields are captured
    // but never published.
    assign unused_bits = ^{shadow[0], shadow[DELIM_IDX_A], shadow[DELIM_IDX_B],
                           shadow[LAST_IDX], numx_word[31:28], nums_word[31:28]};

    // Frame FSM. The last byte is taken straight from rxdata so the commit
    // happens on the edge that samples it, giving a one-clock latency to
    // frame_valid. An aborting byte is swallowed here and never re-examined
    // as a start delimiter; a byte arriving on the expiry cycle takes
    // priority over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            idx         <= '0;
            shadow      <= '0;
            Num_x       <= '0;
            Num_s       <= '0;
            cnt_high    <= '0;
            cnt_low     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (rdsig && (rxdata == DELIM)) begin
                        state <= RECV;
                        idx   <= IDX_W'(1);
                    end
                end
                RECV: begin
                    if (rdsig) begin
                        if (byte_bad) begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                            idx       <= '0;
                        end else if (idx == LAST_IDX) begin
                            Num_x       <= numx_word[27:0];
                            Num_s       <= nums_word[27:0];
                            cnt_high    <= cnth_word;
                            cnt_low     <= {rxdata, shadow[CNTL_START +: 3]};
                            frame_valid <= 1'b1;
                            state       <= HUNT;
                            idx         <= '0;
                        end else begin
                            shadow[idx] <= store_byte;
                            idx         <= idx + IDX_W'(1);
                        end
                    end else if (gap_expired) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                        idx       <= '0;
                    end
                end
                default: begin
                    state <= HUNT;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_parser
// Directed bench for uart_frame_parser with hand-computed expected fields.
// Expectations for the delimiter / nibble frames follow FRAME_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_uart_frame_parser;

    localparam int TIMEOUT = 1024;

    localparam logic [7:0] FRAME_A [19] = '{
        8'h0A, 8'h78, 8'h56, 8'h34, 8'h02, 8'h0A, 8'h21, 8'h43, 8'h65, 8'h07,
        8'h0A, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};

    localparam logic [7:0] FRAME_B [19] = '{
        8'h0A, 8'h11, 8'h22, 8'h33, 8'h04, 8'h0A, 8'h0A, 8'h66, 8'h77, 8'h08,
        8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    logic        clk;
    logic        rst_n;
    logic        rdsig;
    logic [7:0]  rxdata;
    logic [27:0] Num_x;
    logic [27:0] Num_s;
    logic [31:0] cnt_high;
    logic [31:0] cnt_low;
    logic        frame_valid;
    logic        frame_err;

    int compared   = 0;
    int mismatched = 0;
    int validCnt   = 0;
    int errCnt     = 0;
    int v0;
    int e0;

    logic [7:0]  fb [19];
    logic [27:0] expNx;
    logic [27:0] expNs;
    logic [31:0] expCh;
    logic [31:0] expCl;

    uart_frame_parser #(
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdsig       (rdsig),
        .rxdata      (rxdata),
        .Num_x       (Num_x),
        .Num_s       (Num_s),
        .cnt_high    (cnt_high),
        .cnt_low     (cnt_low),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) validCnt++;
        if (frame_err === 1'b1) errCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Idle for 'idle' clocks, then strobe one byte for one clock.
    // Entered and left on a falling edge.
    task automatic applyStimulus(input logic [7:0] b, input int idle);
        repeat (idle) @(negedge clk);
        rdsig  = 1'b1;
        rxdata = b;
        @(negedge clk);
        rdsig  = 1'b0;
        rxdata = 8'h00;
    endtask

    task automatic sendBytes(input int first, input int last, input int idle);
        for (int i = first; i <= last; i++) begin
            applyStimulus(fb[i], idle);
        end
    endtask

    task automatic setExpA();
        expNx = 28'h2345678;
        expNs = 28'h7654321;
        expCh = 32'h11223344;
        expCl = 32'hAABBCCDD;
    endtask

    task automatic setExpB();
        expNx = 28'h4332211;
        expNs = 28'h877660A;
        expCh = 32'h04030201;
        expCl = 32'h08070605;
    endtask

    task automatic checkFields(input string tag);
        checkOutput({tag, "_Num_x"},    {4'h0, Num_x}, {4'h0, expNx});
        checkOutput({tag, "_Num_s"},    {4'h0, Num_s}, {4'h0, expNs});
        checkOutput({tag, "_cnt_high"}, cnt_high,      expCh);
        checkOutput({tag, "_cnt_low"},  cnt_low,       expCl);
    endtask

    initial begin
        rst_n  = 1'b0;
        rdsig  = 1'b0;
        rxdata = 8'h00;
        expNx  = '0;
        expNs  = '0;
        expCh  = '0;
        expCl  = '0;
        repeat (3) @(negedge clk);
        checkFields("reset");
        checkOutput("reset_valid", {31'b0, frame_valid}, 32'd0);
        checkOutput("reset_err",   {31'b0, frame_err},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic frame, 255-clock spacing");
        fb = FRAME_A;
        sendBytes(0, 17, 254);
        checkOutput("t1_early", {31'b0, frame_valid}, 32'd0);
        applyStimulus(fb[18], 254);
        checkOutput("t1_valid", {31'b0, frame_valid}, 32'd1);
        setExpA();
        checkFields("t1");
        @(negedge clk);
        checkOutput("t1_pulse", {31'b0, frame_valid}, 32'd0);

        $display("[TB] bad delimiter at index 5");
        fb = FRAME_B;
        fb[5] = 8'h0B;
`ifdef FRAME_CHECK_EN
        sendBytes(0, 5, 2);
        checkOutput("t2_err", {31'b0, frame_err}, 32'd1);
        checkFields("t2_hold");
`else
        sendBytes(0, 18, 2);
        checkOutput("t2_valid", {31'b0, frame_valid}, 32'd1);
        setExpB();
        checkFields("t2_nochk");
`endif
        fb = FRAME_B;
        sendBytes(0, 18, 2);
        checkOutput("t2_next_valid", {31'b0, frame_valid}, 32'd1);
        setExpB();
        checkFields("t2_next");

        $display("[TB] nonzero upper nibble at index 4");
        fb = FRAME_A;
        fb[4] = 8'h52;
`ifdef FRAME_CHECK_EN
        sendBytes(0, 4, 2);
        checkOutput("t2n_err", {31'b0, frame_err}, 32'd1);
        checkFields("t2n_hold");
`else
        sendBytes(0, 18, 2);
        checkOutput("t2n_valid", {31'b0, frame_valid}, 32'd1);
        setExpA();
        checkFields("t2n_nochk");
`endif

        $display("[TB] inter-byte timeout");
        fb = FRAME_B;
        sendBytes(0, 7, 2);
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("t3_early", {31'b0, frame_err}, 32'd0);
        @(negedge clk);
        checkOutput("t3_err", {31'b0, frame_err}, 32'd1);
        checkFields("t3_hold");
        repeat (1100 - TIMEOUT) @(negedge clk);
        fb = FRAME_A;
        sendBytes(0, 18, 2);
        checkOutput("t3_next_valid", {31'b0, frame_valid}, 32'd1);
        setExpA();
        checkFields("t3_next");

        $display("[TB] leading garbage");
        #1;
        v0 = validCnt;
        applyStimulus(8'h55, 2);
        applyStimulus(8'hAA, 2);
        applyStimulus(8'hFF, 2);
        fb = FRAME_B;
        sendBytes(0, 18, 1);
        checkOutput("t4_valid", {31'b0, frame_valid}, 32'd1);
        setExpB();
        checkFields("t4");
        repeat (2) @(negedge clk);
        #1;
        checkOutput("t4_count", validCnt - v0, 32'd1);

        $display("[TB] reset mid-frame");
        e0 = errCnt;
        fb = FRAME_A;
        sendBytes(0, 12, 2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        expNx = '0;
        expNs = '0;
        expCh = '0;
        expCl = '0;
        checkFields("t5_rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("t5_errcnt", errCnt - e0, 32'd0);
        fb = FRAME_B;
        sendBytes(0, 18, 2);
        checkOutput("t5_valid", {31'b0, frame_valid}, 32'd1);
        setExpB();
        checkFields("t5");

        $display("[TB] back-to-back frames");
        fb = FRAME_A;
        sendBytes(0, 18, 0);
        checkOutput("t6a_valid", {31'b0, frame_valid}, 32'd1);
        setExpA();
        checkFields("t6a");
        fb = FRAME_B;
        sendBytes(0, 18, 0);
        checkOutput("t6b_valid", {31'b0, frame_valid}, 32'd1);
        setExpB();
        checkFields("t6b");

        $display("[TB] byte on the expiry cycle");
        #1;
        e0 = errCnt;
        fb = FRAME_A;
        sendBytes(0, 8, 1);
        applyStimulus(fb[9], TIMEOUT - 1);
        applyStimulus(fb[10], TIMEOUT - 1);
        sendBytes(11, 18, 1);
        checkOutput("t7_valid", {31'b0, frame_valid}, 32'd1);
        setExpA();
        checkFields("t7");
        repeat (2) @(negedge clk);
        #1;
        checkOutput("t7_errcnt", errCnt - e0, 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
